compare_sequencer: RTL

//  Multi-cycle N-bit magnitude compare controller for the ALU.
//  - Time-multiplexes one narrow SLICE-bit comparator stage over a wide operand pair, MSB slice first.
//  - Start/busy/done handshake; one-hot lt/eq/gt result held until the next start.
//  - Sits between ALU op decode and the flag register; reuses the slice comparator instead of a WIDTH-bit one.

---
 rtl/compare_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/compare_sequencer.sv
// Multi-cycle unsigned magnitude comparator. One Slice-bit comparator stage is
// reused across the operand, MSB slice first; the first unequal slice decides
// the result. Start/busy/done handshake with a one-hot lt/eq/gt result held
// until the next accepted start.
//
// Optional build macro: EARLY_EXIT_EN -- when defined, the scan stops on the
// first unequal slice instead of always visiting every slice. Flag values are
// the same in both builds; only latency differs.
module compare_sequencer #(
  parameter int unsigned Width = 12,
  parameter int unsigned Slice = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             lt_o,
  output logic             eq_o,
  output logic             gt_o
);

  localparam int unsigned NSlice = Width / Slice;
  localparam int unsigned IdxW   = (NSlice > 1) ? $clog2(NSlice) : 1;

  localparam logic [IdxW-1:0] IdxLast = IdxW'(NSlice - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Sticky diff encoding: DiffNone means no unequal slice seen yet.
  localparam logic [1:0] DiffNone = 2'd0;
  localparam logic [1:0] DiffLt   = 2'd1;
  localparam logic [1:0] DiffGt   = 2'd2;

  if ((Width % Slice) != 0) begin : g_bad_cfg
    $error("compare_sequencer: Width must be an integer multiple of Slice");
  end

  logic [1:0]       state_q, state_d;
  logic [Width-1:0] a_q, a_d;
  logic [Width-1:0] b_q, b_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [1:0]       diff_q, diff_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  logic [31:0]      shamt;
  logic [Width-1:0] a_shift, b_shift;
  logic [Slice-1:0] a_slice, b_slice;
  logic [1:0]       diff_new;
  logic             scan_end;

  // Select the current slice from the captured operands.
  assign shamt   = 32'(idx_q) * Slice;
  assign a_shift = a_q >> shamt;
  assign b_shift = b_q >> shamt;
  assign a_slice = a_shift[Slice-1:0];
  assign b_slice = b_shift[Slice-1:0];

  // First unequal slice wins; later slices never overwrite the recorded diff.
  always_comb begin
    diff_new = diff_q;
    if (diff_q == DiffNone) begin
      if (a_slice < b_slice) begin
        diff_new = DiffLt;
      end else if (a_slice > b_slice) begin
        diff_new = DiffGt;
      end
    end
  end

`ifdef EARLY_EXIT_EN
  assign scan_end = (idx_q == '0) || (diff_new != DiffNone);
`else
  assign scan_end = (idx_q == '0);
`endif

  // Next-state logic for the controller, operand capture and result flags.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          idx_d   = IdxLast;
          diff_d  = DiffNone;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = StScan;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StScan: begin
        diff_d = diff_new;
        if (scan_end) begin
          lt_d    = (diff_new == DiffLt);
          gt_d    = (diff_new == DiffGt);
          eq_d    = (diff_new == DiffNone);
          state_d = StDone;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      diff_q  <= DiffNone;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign busy_o = (state_q == StScan);
  assign done_o = (state_q == StDone);
  assign lt_o   = lt_q;
  assign eq_o   = eq_q;
  assign gt_o   = gt_q;

endmodule
